// File: rtl/mt_pkg.sv
// Shared multithreading types: hart count, hart ID and per-hart run state.
// The forwarding and hazard units import this package as well.
package mt_pkg;

  localparam int NUM_HARTS = 4;

  typedef logic [1:0] hart_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WAIT  = 2'd2
  } hart_state_e;

  // Round-robin pick. The scan starts just after ptr and visits every hart
  // exactly once, so the last hart selected has the lowest priority.
  // Returns hart 0 when no hart is available.
  function automatic hart_id_t rr_pick(input hart_id_t ptr,
                                       input logic [NUM_HARTS-1:0] avail);
    hart_id_t idx;
    hart_id_t sel;
    logic     found;
    sel   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NUM_HARTS; k++) begin
      idx = idx + hart_id_t'(1);
      if (!found && avail[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hart_ctx.sv
// Run-state context for one hart: IDLE/READY/WAIT FSM plus the park counter.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | hart disabled; cnt held at 0
//   READY | hart may be fetched (unless parked this very cycle)
//   WAIT  | hart parked; cnt counts down on non-stalled cycles
//
// Enable low dominates everything. A block in WAIT merges by taking the
// longer of the remaining and requested park, and suppresses the countdown
// for that cycle.
module hart_ctx
  import mt_pkg::*;
#(
  parameter int WAIT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_stall,
  input  logic              i_block,
  input  logic [WAIT_W-1:0] i_block_cycles,
  output logic              o_ready
);

  hart_state_e       r_state;
  hart_state_e       w_state_nxt;
  logic [WAIT_W-1:0] r_cnt;
  logic [WAIT_W-1:0] w_cnt_nxt;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: enable, then block, then countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!i_enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end
        READY: begin
          if (i_block) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = i_block_cycles;
          end
        end
        WAIT: begin
          if (i_block) begin
            w_cnt_nxt = (i_block_cycles > r_cnt) ? i_block_cycles : r_cnt;
          end else if (!i_stall) begin
            if (r_cnt == WAIT_W'(1)) begin
              w_state_nxt = READY;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - WAIT_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_ready = (r_state == READY);

endmodule

// File: rtl/hart_scheduler.sv
// Per-cycle fetch hart selector for the 4-hart pipeline. Outputs are purely
// combinational from the hart contexts, the round-robin pointer and the
// same-cycle block mask, so IF can use fetch_hart in the cycle it appears.
module hart_scheduler
  import mt_pkg::*;
#(
  parameter int WAIT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_HARTS-1:0] hart_enable,
  input  logic                 stall_IF,
  input  logic                 block_valid,
  input  logic [1:0]           block_hart,
  input  logic [WAIT_W-1:0]    block_cycles,
  output logic                 fetch_valid,
  output logic [1:0]           fetch_hart,
  output logic [NUM_HARTS-1:0] hart_ready
);

  logic [NUM_HARTS-1:0] w_block_hit;
  logic [NUM_HARTS-1:0] w_ready;
  logic [NUM_HARTS-1:0] w_avail;
  hart_id_t             w_sel;
  hart_id_t             r_rr_ptr;

  // Decode the park request; a zero length is not a request at all.
  always_comb begin
    w_block_hit = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      w_block_hit[i] = block_valid && (block_hart == hart_id_t'(i)) &&
                       (block_cycles != '0);
    end
  end

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    hart_ctx #(
      .WAIT_W(WAIT_W)
    ) u_ctx (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_enable      (hart_enable[g]),
      .i_stall       (stall_IF),
      .i_block       (w_block_hit[g]),
      .i_block_cycles(block_cycles),
      .o_ready       (w_ready[g])
    );
  end

  // A hart parked this cycle is masked immediately, not one cycle later.
  assign w_avail     = w_ready & ~w_block_hit;
  assign w_sel       = rr_pick(r_rr_ptr, w_avail);
  assign fetch_valid = |w_avail;
  assign fetch_hart  = w_sel;
  assign hart_ready  = w_ready;

  // Round-robin pointer; reset to 3 so hart 0 is scanned first. Holding it
  // while stalled keeps fetch_hart stable across the stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= hart_id_t'(NUM_HARTS - 1);
    end else if (fetch_valid && !stall_IF) begin
      r_rr_ptr <= fetch_hart;
    end
  end

endmodule

// File: tb/tb_hart_scheduler.sv
// Bench for hart_scheduler: a behavioural model (per hart: "switched on" flag
// plus remaining park cycles; a scan pointer) checked every negedge, directed
// scenarios with hand-computed literal expectations, then random traffic.
module tb_hart_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] hart_enable;
  logic       stall_IF;
  logic       block_valid;
  logic [1:0] block_hart;
  logic [2:0] block_cycles;
  logic       fetch_valid;
  logic [1:0] fetch_hart;
  logic [3:0] hart_ready;

  int vectors = 0;
  int errors  = 0;

  hart_scheduler #(.WAIT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hart_enable (hart_enable),
    .stall_IF    (stall_IF),
    .block_valid (block_valid),
    .block_hart  (block_hart),
    .block_cycles(block_cycles),
    .fetch_valid (fetch_valid),
    .fetch_hart  (fetch_hart),
    .hart_ready  (hart_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: a hart is ready when it is switched on and has no park left.
  bit m_on   [4] = '{0, 0, 0, 0};
  int m_park [4] = '{0, 0, 0, 0};
  int m_ptr      = 3;

  function automatic void model_eval(output logic v, output logic [1:0] h,
                                     output logic [3:0] r);
    logic [3:0] av;
    bit found;
    for (int i = 0; i < 4; i++) begin
      r[i]  = m_on[i] && (m_park[i] == 0);
      av[i] = r[i] && !(block_valid && block_hart == 2'(i) && block_cycles != 3'd0);
    end
    v = |av;
    h = 2'd0;
    found = 0;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (!found && av[idx]) begin
        h = 2'(idx);
        found = 1;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_on[i]   = 0;
        m_park[i] = 0;
      end
      m_ptr = 3;
    end else begin
      logic       v;
      logic [1:0] h;
      logic [3:0] r;
      model_eval(v, h, r);
      if (v && !stall_IF) m_ptr = int'(h);
      for (int i = 0; i < 4; i++) begin
        if (!hart_enable[i]) begin
          m_on[i]   = 0;
          m_park[i] = 0;
        end else if (!m_on[i]) begin
          m_on[i] = 1;
        end else if (block_valid && block_hart == 2'(i) && block_cycles != 3'd0) begin
          if (int'(block_cycles) > m_park[i]) m_park[i] = int'(block_cycles);
        end else if (m_park[i] > 0 && !stall_IF) begin
          m_park[i] = m_park[i] - 1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic       ev;
    logic [1:0] eh;
    logic [3:0] er;
    model_eval(ev, eh, er);
    vectors++;
    if (fetch_valid !== ev || fetch_hart !== eh || hart_ready !== er) begin
      errors++;
      $display("FAIL model t=%0t: got valid=%0b hart=%0d ready=%b, want valid=%0b hart=%0d ready=%b",
               $time, fetch_valid, fetch_hart, hart_ready, ev, eh, er);
    end
  end

  task automatic lit_f(input string nm, input logic ev, input logic [1:0] eh);
    vectors++;
    if (fetch_valid !== ev || fetch_hart !== eh) begin
      errors++;
      $display("FAIL %s t=%0t: got valid=%0b hart=%0d, want valid=%0b hart=%0d",
               nm, $time, fetch_valid, fetch_hart, ev, eh);
    end
  endtask

  task automatic lit_r(input string nm, input logic [3:0] er);
    vectors++;
    if (hart_ready !== er) begin
      errors++;
      $display("FAIL %s t=%0t: got ready=%b, want ready=%b", nm, $time, hart_ready, er);
    end
  endtask

  task automatic go_neg();
    @(negedge clk);
  endtask

  task automatic go_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] seq_blk [3];
    seq_blk = '{2'd3, 2'd0, 2'd1};

    rst_n        = 1'b0;
    hart_enable  = 4'b1111;
    stall_IF     = 1'b0;
    block_valid  = 1'b0;
    block_hart   = 2'd0;
    block_cycles = 3'd0;
    go_next();
    go_next();
    lit_f("reset_out", 1'b0, 2'd0);
    lit_r("reset_ready", 4'b0000);
    rst_n = 1'b1;

    // Full rotation: cycle 0 harts still IDLE, then 0,1,2,3,...
    go_neg(); lit_f("rot_c0", 1'b0, 2'd0); lit_r("rot_c0_ready", 4'b0000); go_next();
    for (int i = 1; i <= 9; i++) begin
      go_neg();
      lit_f("rotation", 1'b1, 2'((i - 1) % 4));
      if (i == 1) lit_r("rot_ready", 4'b1111);
      go_next();
    end

    // Cycle 9 fetched hart 0; park hart 1 for 2 cycles in cycle 10.
    block_valid = 1'b1; block_hart = 2'd1; block_cycles = 3'd2;
    go_neg(); lit_f("blk_sel_c1", 1'b1, 2'd2); go_next();
    block_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      go_neg(); lit_f("blk_sel", 1'b1, seq_blk[i]); go_next();
    end

    // Three stalled cycles: fetch_hart stable, pointer held.
    stall_IF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      go_neg(); lit_f("stall_hold", 1'b1, 2'd2); go_next();
    end
    stall_IF = 1'b0;
    go_neg(); lit_f("stall_after", 1'b1, 2'd2); go_next();
    go_neg(); lit_f("stall_after2", 1'b1, 2'd3); go_next();

    // Park hart 0 for 2, then stall 3 cycles: counter frozen.
    block_valid = 1'b1; block_hart = 2'd0; block_cycles = 3'd2;
    go_neg(); lit_f("park_mask", 1'b1, 2'd1); go_next();
    block_valid = 1'b0;
    stall_IF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      go_neg(); lit_f("park_stall", 1'b1, 2'd2); lit_r("park_stall_ready", 4'b1110); go_next();
    end
    stall_IF = 1'b0;
    go_neg(); lit_r("park_frozen1", 4'b1110); go_next();
    go_neg(); lit_r("park_frozen2", 4'b1110); go_next();
    go_neg(); lit_r("park_done", 4'b1111); lit_f("park_done_sel", 1'b1, 2'd0); go_next();

    // Merge: hart 1 parked with cnt=2, re-blocked with 5 -> ready 6 cycles later.
    block_valid = 1'b1; block_hart = 2'd1; block_cycles = 3'd2;
    go_neg(); lit_f("merge_c0", 1'b1, 2'd2); go_next();
    block_cycles = 3'd5;
    go_neg(); lit_f("merge_c1", 1'b1, 2'd3); go_next();
    block_valid = 1'b0;
    for (int i = 0; i < 4; i++) go_next();
    go_neg(); lit_r("merge_wait", 4'b1101); go_next();
    go_neg(); lit_r("merge_ready", 4'b1111); go_next();

    // Disable latency, then a lone hart parked for 1 cycle.
    hart_enable = 4'b0001;
    go_neg(); lit_r("disable_same_cycle", 4'b1111); go_next();
    block_valid = 1'b1; block_hart = 2'd0; block_cycles = 3'd1;
    go_neg(); lit_r("disable_next", 4'b0001); lit_f("none_avail1", 1'b0, 2'd0); go_next();
    block_valid = 1'b0;
    go_neg(); lit_f("none_avail2", 1'b0, 2'd0); go_next();
    go_neg(); lit_f("none_avail_end", 1'b1, 2'd0); go_next();

    // Sparse enables 0101.
    hart_enable = 4'b0101;
    go_neg(); lit_f("sparse_c0", 1'b1, 2'd0); go_next();
    go_neg(); lit_f("sparse_a", 1'b1, 2'd2); go_next();
    go_neg(); lit_f("sparse_b", 1'b1, 2'd0); go_next();
    go_neg(); lit_f("sparse_c", 1'b1, 2'd2); lit_r("sparse_ready", 4'b0101); go_next();

    // Mid-operation asynchronous reset.
    hart_enable = 4'b1111;
    for (int i = 0; i < 6; i++) go_next();
    #2;
    rst_n = 1'b0;
    #1;
    lit_f("async_reset", 1'b0, 2'd0);
    lit_r("async_reset_ready", 4'b0000);
    go_next();
    rst_n = 1'b1;
    go_neg(); lit_f("rst_restart_c0", 1'b0, 2'd0); go_next();
    go_neg(); lit_f("rst_restart_c1", 1'b1, 2'd0); go_next();
    go_neg(); lit_f("rst_restart_c2", 1'b1, 2'd1); go_next();

    // Random traffic against the model.
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) begin
        int b;
        b = int'($urandom_range(0, 3));
        hart_enable[b] = ~hart_enable[b];
      end
      block_valid  = ($urandom_range(0, 2) == 0);
      block_hart   = 2'($urandom_range(0, 3));
      block_cycles = 3'($urandom_range(0, 7));
      stall_IF     = ($urandom_range(0, 4) == 0);
      go_next();
    end

    go_neg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
